// File: rtl/cpu_pkg.sv
// Shared CPU definitions: T-state constants, sequencer state encoding and
// the default stage counts used by both the sequencer and control_block.
package cpu_pkg;

    localparam logic [2:0] STAGE_T0 = 3'd0;
    localparam logic [2:0] STAGE_T1 = 3'd1;
    localparam logic [2:0] STAGE_T2 = 3'd2;
    localparam logic [2:0] STAGE_T3 = 3'd3;
    localparam logic [2:0] STAGE_T4 = 3'd4;
    localparam logic [2:0] STAGE_T5 = 3'd5;
    localparam logic [2:0] STAGE_T6 = 3'd6;
    localparam logic [2:0] STAGE_T7 = 3'd7;

    localparam int DEFAULT_NUM_STAGES   = 6;
    localparam int DEFAULT_FETCH_STAGES = 2;

    typedef enum logic [1:0] {
        SEQ_RUN       = 2'd0,
        SEQ_STEP_WAIT = 2'd1,
        SEQ_HALTED    = 2'd2
    } seq_state_e;

    // One-hot decode of a stage index; bits at or above num_stages stay 0
    // so control_block never sees a select for a stage that cannot occur.
    function automatic logic [7:0] stage_onehot_mask(input logic [2:0] stage_idx,
                                                     input int num_stages);
        logic [7:0] oh;
        oh = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if ((i < num_stages) && (stage_idx == i[2:0])) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/cpu_stage_sequencer_step_pulse_gen.sv
// Rising-edge detector for the front-panel single-step request. A level held
// high yields exactly one pulse; the history register clears on reset.
module step_pulse_gen (
    input  logic clk,
    input  logic rst,
    input  logic step_req_i,
    output logic step_pulse_o
);

    logic step_req_q;

    // Remember last cycle's request level so only a 0->1 change counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_req_q <= 1'b0;
        end else begin
            step_req_q <= step_req_i;
        end
    end

    assign step_pulse_o = step_req_i & ~step_req_q;

endmodule

// File: rtl/cpu_stage_sequencer.sv
// T-state sequencer for the 8-bit CPU. Produces the stage index consumed by
// control_block and gates when the datapath may act (free-run, single-step,
// early instruction end, halt).
// Optional build macro CPU_STAGE_SEQ_INSTR_COUNT_EN adds an 8-bit
// retired-instruction counter output (retired_count).
module cpu_stage_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES   = DEFAULT_NUM_STAGES,
    parameter int FETCH_STAGES = DEFAULT_FETCH_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       step_req,
    input  logic       early_end,
    input  logic       halt_req,
    output logic [2:0] stage,
    output logic [7:0] stage_onehot,
    output logic       fetch_phase,
    output logic       instr_boundary,
    output logic       halted,
    output logic       stage_valid
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
    ,
    output logic [7:0] retired_count
`endif
);

    localparam logic [2:0] LAST_STAGE  = 3'(NUM_STAGES - 1);
    localparam logic [2:0] FETCH_LIMIT = 3'(FETCH_STAGES);

    seq_state_e state_q, state_d;
    logic [2:0] stage_q, stage_d;
    logic [7:0] onehot_q;
    logic       fetch_q;
    logic       boundary_q;
    logic       halted_q;
    logic       step_pulse;
    logic       valid_c;
    logic       wrap_d;
    logic [2:0] plus_one;

    step_pulse_gen u_step_pulse (
        .clk          (clk),
        .rst          (rst),
        .step_req_i   (step_req),
        .step_pulse_o (step_pulse)
    );

    // Decide whether this cycle's stage is live and compute the next stage
    // and mode; halt wins over early end, and a halting stage still advances.
    always_comb begin
        valid_c  = 1'b0;
        stage_d  = stage_q;
        state_d  = state_q;
        plus_one = (stage_q == LAST_STAGE) ? STAGE_T0 : (stage_q + 3'd1);

        if (!rst) begin
            case (state_q)
                SEQ_RUN:       valid_c = 1'b1;
                SEQ_STEP_WAIT: valid_c = step_pulse;
                default:       valid_c = 1'b0;
            endcase
        end

        if (valid_c) begin
            if (halt_req) begin
                stage_d = plus_one;
            end else if (early_end && (stage_q >= FETCH_LIMIT)) begin
                stage_d = STAGE_T0;
            end else begin
                stage_d = plus_one;
            end
        end

        if (valid_c && halt_req) begin
            state_d = SEQ_HALTED;
        end else begin
            case (state_q)
                SEQ_RUN:       if (!run_en) state_d = SEQ_STEP_WAIT;
                SEQ_STEP_WAIT: if (run_en)  state_d = SEQ_RUN;
                default:       state_d = state_q;
            endcase
        end

        wrap_d = valid_c && (stage_d == STAGE_T0);
    end

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_RUN;
            stage_q    <= STAGE_T0;
            onehot_q   <= 8'h01;
            fetch_q    <= 1'b1;
            boundary_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            onehot_q   <= stage_onehot_mask(stage_d, NUM_STAGES);
            fetch_q    <= (stage_d < FETCH_LIMIT) && (state_d != SEQ_HALTED);
            boundary_q <= wrap_d;
            halted_q   <= (state_d == SEQ_HALTED);
        end
    end

`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
    logic [7:0] retired_q;

    // Count completed instructions; bumps on the same edge the boundary
    // pulse is raised, so it naturally holds once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 8'd0;
        end else if (wrap_d) begin
            retired_q <= retired_q + 8'd1;
        end
    end

    assign retired_count = retired_q;
`else
    // No retirement counter in this build.
`endif

    assign stage          = stage_q;
    assign stage_onehot   = onehot_q;
    assign fetch_phase    = fetch_q;
    assign instr_boundary = boundary_q;
    assign halted         = halted_q;
    assign stage_valid    = valid_c;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: a spec-level model pushes the
// expected outputs for each applied vector into a queue; each test pops and
// compares after the clock edge, plus fixed expectations from the test plan.
module tb_cpu_stage_sequencer;

    localparam int NS = 6;
    localparam int FS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b0;
    logic       step_req = 1'b0;
    logic       early_end = 1'b0;
    logic       halt_req = 1'b0;
    logic [2:0] stage;
    logic [7:0] stage_onehot;
    logic       fetch_phase;
    logic       instr_boundary;
    logic       halted;
    logic       stage_valid;
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
    logic [7:0] retired_count;
`endif

    cpu_stage_sequencer #(.NUM_STAGES(NS), .FETCH_STAGES(FS)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_en         (run_en),
        .step_req       (step_req),
        .early_end      (early_end),
        .halt_req       (halt_req),
        .stage          (stage),
        .stage_onehot   (stage_onehot),
        .fetch_phase    (fetch_phase),
        .instr_boundary (instr_boundary),
        .halted         (halted),
        .stage_valid    (stage_valid)
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
        ,
        .retired_count  (retired_count)
`endif
    );

    always #5 clk = ~clk;

    // valid is the pre-edge combinational value; the rest are post-edge.
    typedef struct packed {
        logic       valid;
        logic [2:0] stage;
        logic [7:0] onehot;
        logic       fetch;
        logic       boundary;
        logic       halted;
        logic [7:0] count;
    } obs_t;

    obs_t scoreQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: 0 = RUN, 1 = STEP_WAIT, 2 = HALTED
    int   mState = 0;
    int   mStage = 0;
    bit   mPrev = 1'b0;
    int   mCount = 0;
    logic lastValid;

    function automatic obs_t sampleOutputs();
        obs_t o;
        o.valid    = lastValid;
        o.stage    = stage;
        o.onehot   = stage_onehot;
        o.fetch    = fetch_phase;
        o.boundary = instr_boundary;
        o.halted   = halted;
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
        o.count    = retired_count;
`else
        o.count    = 8'd0;
`endif
        return o;
    endfunction

    // Drive one cycle of inputs, push the model's expectation, clock once.
    task automatic applyStimulus(input bit r, input bit run, input bit step,
                                 input bit early, input bit halt);
        obs_t e;
        bit   expValid;
        bit   expBoundary;
        int   nxt;
        @(negedge clk);
        rst = r; run_en = run; step_req = step; early_end = early; halt_req = halt;
        #1;
        expValid = !r && ((mState == 0) || ((mState == 1) && step && !mPrev));
        expBoundary = 1'b0;
        if (r) begin
            mState = 0; mStage = 0; mPrev = 1'b0; mCount = 0;
        end else begin
            mPrev = step;
            if (expValid) begin
                if (halt) nxt = (mStage == NS - 1) ? 0 : mStage + 1;
                else if ((mStage == NS - 1) || (early && mStage >= FS)) nxt = 0;
                else nxt = mStage + 1;
                expBoundary = (nxt == 0);
                mStage = nxt;
                if (expBoundary) mCount = (mCount + 1) % 256;
            end
            if (expValid && halt) mState = 2;
            else if (mState == 0 && !run) mState = 1;
            else if (mState == 1 && run) mState = 0;
        end
        e.valid    = expValid;
        e.stage    = mStage[2:0];
        e.onehot   = 8'(1 << mStage);
        e.fetch    = (mStage < FS) && (mState != 2);
        e.boundary = expBoundary;
        e.halted   = (mState == 2);
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
        e.count    = mCount[7:0];
`else
        e.count    = 8'd0;
`endif
        scoreQ.push_back(e);
        lastValid = stage_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL reset cyc%0d: got %h want %h (valid,stage,onehot,fetch,bnd,halt,cnt)", i, got, want);
            end
        end
        vectors++;
        if (stage !== 3'd0 || stage_onehot !== 8'h01 || fetch_phase !== 1'b1 ||
            instr_boundary !== 1'b0 || halted !== 1'b0 || lastValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: stage %0d oh %h fetch %b bnd %b halt %b valid %b, want 0 01 1 0 0 0",
                     stage, stage_onehot, fetch_phase, instr_boundary, halted, lastValid);
        end
    endtask

    task automatic test_free_run();
        obs_t got, want;
        int seq [14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL free_run cyc%0d: got %h want %h", i, got, want);
            end
            vectors++;
            if (stage !== seq[i][2:0] || instr_boundary !== (seq[i] == 0)) begin
                miscompares++;
                $display("[TB] FAIL free_run_seq cyc%0d: stage %0d bnd %b, want %0d %b",
                         i, stage, instr_boundary, seq[i], seq[i] == 0);
            end
        end
    endtask

    task automatic test_early_end();
        obs_t got, want;
        bit   early [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   expStage [4] = '{3, 0, 1, 2};
        bit   expBnd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, early[i], 1'b0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL early_end cyc%0d: got %h want %h", i, got, want);
            end
            vectors++;
            if (stage !== expStage[i][2:0] || instr_boundary !== expBnd[i]) begin
                miscompares++;
                $display("[TB] FAIL early_end_fixed cyc%0d: stage %0d bnd %b, want %0d %b",
                         i, stage, instr_boundary, expStage[i], expBnd[i]);
            end
        end
    endtask

    task automatic test_single_step();
        obs_t got, want;
        int   validSeen;
        for (int k = 0; k < 8 && mStage != 1; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL step_setup cyc%0d: got %h want %h", k, got, want);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL step_enter: got %h want %h stage %0d want 2", got, want, stage);
        end
        validSeen = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (lastValid === 1'b1) validSeen++;
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want || stage !== 3'd3) begin
                miscompares++;
                $display("[TB] FAIL step_hold cyc%0d: got %h want %h stage %0d want 3", i, got, want, stage);
            end
        end
        vectors++;
        if (validSeen != 1) begin
            miscompares++;
            $display("[TB] FAIL step_hold_valid: valid cycles %0d want 1", validSeen);
        end
        validSeen = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 2), 1'b0, 1'b0);
            if (lastValid === 1'b1) validSeen++;
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want || stage !== ((i >= 2) ? 3'd4 : 3'd3)) begin
                miscompares++;
                $display("[TB] FAIL step_again cyc%0d: got %h want %h stage %0d", i, got, want, stage);
            end
        end
        vectors++;
        if (validSeen != 1) begin
            miscompares++;
            $display("[TB] FAIL step_again_valid: valid cycles %0d want 1", validSeen);
        end
    endtask

    task automatic test_halt();
        obs_t got, want;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL halt_resume: got %h want %h stage %0d want 4", got, want, stage);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd5 || halted !== 1'b1 || fetch_phase !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL halt_enter: got %h want %h stage %0d halted %b", got, want, stage, halted);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 3) != 0, i[0], 1'b1, i[1]);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want || stage !== 3'd5 || halted !== 1'b1 || lastValid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL halt_frozen cyc%0d: got %h want %h stage %0d", i, got, want, stage);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd0 || halted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL halt_reset: got %h want %h stage %0d halted %b", got, want, stage, halted);
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, want;
        for (int k = 0; k < 8 && mStage != 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL mid_setup cyc%0d: got %h want %h", k, got, want);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd0 || halted !== 1'b0 || got.count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got %h want %h stage %0d halted %b", got, want, stage, halted);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want || stage !== 3'd1 || lastValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_run: got %h want %h stage %0d valid %b", got, want, stage, lastValid);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL b2b_reset: got %h want %h", got, want);
        end
        for (int i = 0; i < 256 * NS; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL b2b cyc%0d: got %h want %h", i, got, want);
            end
`ifdef CPU_STAGE_SEQ_INSTR_COUNT_EN
            if (i == 255 * NS - 1) begin
                vectors++;
                if (retired_count !== 8'd255) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_count255: got %0d want 255", retired_count);
                end
            end
`endif
        end
        vectors++;
        if (stage !== 3'd0 || instr_boundary !== 1'b1 || got.count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wrap: stage %0d bnd %b count %0d, want 0 1 0", stage, instr_boundary, got.count);
        end
    endtask

    task automatic test_random();
        obs_t got, want;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 50) == 0, ($urandom % 3) != 0, $urandom % 2,
                          ($urandom % 4) == 0, ($urandom % 40) == 0);
            got = sampleOutputs(); want = scoreQ.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL random cyc%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_early_end();
        test_single_step();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
